// File: rtl/excess3_multi_to_binary_if.sv
// Handshake bundle between an excess-3 producer and the excess3_multi_to_binary converter.
// err_pos exists only when E3B_ERR_POS_EN is defined.
interface excess3_multi_to_binary_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
);
  logic [4*DIGITS-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;
`ifdef E3B_ERR_POS_EN
  logic [$clog2(DIGITS+1)-1:0] err_pos;
`endif

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
`ifdef E3B_ERR_POS_EN
    , output err_pos
`endif
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
`ifdef E3B_ERR_POS_EN
    , input err_pos
`endif
  );
endinterface

// File: rtl/excess3_multi_to_binary.sv
// Sequential excess-3 word to binary converter, one digit per cycle, MS digit first.
// Optional feature: define E3B_ERR_POS_EN to add err_pos (index of most significant invalid digit).
module excess3_multi_to_binary #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  excess3_multi_to_binary_if.slave  io_bus
);
  localparam int IN_W  = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IN_W-1:0]  r_shift;
  logic [OUT_W-1:0] r_acc;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_outData;
  logic             r_outErr;

  logic             w_capture;
  logic             w_step;
  logic             w_inReady;
  logic             w_outValid;
  logic [3:0]       w_nib;
  logic             w_invalid;
  logic [3:0]       w_digit;
  logic [OUT_W-1:0] w_accNext;
  logic             w_lastDigit;

  // The MS digit always sits at the top of the shift register.
  assign w_nib       = r_shift[IN_W-1 -: 4];
  assign w_invalid   = (w_nib < 4'd3) || (w_nib > 4'd12);
  assign w_digit     = w_invalid ? 4'd0 : (w_nib - 4'd3);
  assign w_accNext   = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_digit);
  assign w_lastDigit = (r_cnt == CNT_W'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (io_bus.in_valid) begin
          w_capture   = 1'b1;
          w_nextState = CONV;
        end
      end
      CONV: begin
        w_step = 1'b1;
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (io_bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Accumulator wraps modulo 2^OUT_W; results are published only on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_outData <= '0;
      r_outErr  <= 1'b0;
    end else if (w_capture) begin
      r_shift <= io_bus.in_data;
      r_acc   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_shift <= r_shift << 4;
      r_acc   <= w_accNext;
      r_err   <= r_err | w_invalid;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_lastDigit) begin
        r_outData <= w_accNext;
        r_outErr  <= r_err | w_invalid;
      end
    end
  end

  assign io_bus.in_ready  = w_inReady;
  assign io_bus.out_valid = w_outValid;
  assign io_bus.out_data  = r_outData;
  assign io_bus.out_err   = r_outErr;

`ifdef E3B_ERR_POS_EN
  localparam int POS_W = $clog2(DIGITS + 1);

  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] r_outPos;
  logic [POS_W-1:0] w_digitIdx;
  logic             w_firstBad;

  // Only the first invalid digit seen (the most significant one) is recorded.
  assign w_digitIdx = POS_W'(DIGITS - 1) - POS_W'(r_cnt);
  assign w_firstBad = w_invalid && !r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos    <= POS_W'(DIGITS);
      r_outPos <= POS_W'(DIGITS);
    end else if (w_capture) begin
      r_pos <= POS_W'(DIGITS);
    end else if (w_step) begin
      if (w_firstBad) begin
        r_pos <= w_digitIdx;
      end
      if (w_lastDigit) begin
        r_outPos <= w_firstBad ? w_digitIdx : r_pos;
      end
    end
  end

  assign io_bus.err_pos = r_outPos;
`endif
endmodule
